// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//
// Lets two SPI masters (requester 0 = CPU, requester 1 = DMA/peripheral)
// share one SPI bus. A requester holds reqX high for its whole transaction.
// The bus is handed out round-robin when both ask at once. After every
// release a guard interval keeps chip select high before the next owner can
// drive the bus.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   req0/req1                 bus requests, held for the whole transaction
//   sel0_n/sel1_n             requester chip selects (active-low)
//   mosi0/mosi1               requester serial data out
//   clk_en0/clk_en1           requester SPI clock enables
//   gnt0/gnt1                 grant indications (never both high)
//   spi_miso                  shared bus serial data in
//   miso0/miso1               per-requester serial data in (gated by grant)
//   spi_select                bus chip select, active-low, registered
//   spi_mosi                  bus serial data out, registered
//   spi_clk_enable            bus clock enable, registered
//   busy                      arbiter is not idle
//
// GUARD_CYCLES (1..15) sets the guard length. spi_select stays high for at
// least GUARD_CYCLES+1 cycles between two ownerships: GUARD_CYCLES cycles in
// GUARD plus one in IDLE.

module spi_bus_arbiter #(
    parameter int GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,

    input  logic req0,
    input  logic sel0_n,
    input  logic mosi0,
    input  logic clk_en0,
    output logic gnt0,

    input  logic req1,
    input  logic sel1_n,
    input  logic mosi1,
    input  logic clk_en1,
    output logic gnt1,

    input  logic spi_miso,
    output logic miso0,
    output logic miso1,

    output logic spi_select,
    output logic spi_mosi,
    output logic spi_clk_enable,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        GUARD = 2'd3
    } state_t;

    // The counter is loaded with GUARD_CYCLES-1 and the FSM leaves GUARD on
    // the cycle the counter reads zero. That gives exactly GUARD_CYCLES
    // cycles in GUARD.
    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_t     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic [3:0] guard_cnt_q, guard_cnt_d;
    logic       spi_select_q, spi_select_d;
    logic       spi_mosi_q, spi_mosi_d;
    logic       spi_clk_enable_q, spi_clk_enable_d;

    // Next-state and next-output logic. The bus outputs default to the
    // inactive pattern. Only a cycle that stays in OWNx passes the owner's
    // signals through. The entry edge into OWNx still registers the inactive
    // pattern, so the owner's select shows up one cycle after its grant.
    always_comb begin
        state_d          = state_q;
        last_owner_d     = last_owner_q;
        guard_cnt_d      = guard_cnt_q;
        spi_select_d     = 1'b1;
        spi_mosi_d       = 1'b0;
        spi_clk_enable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    // Round-robin: favour whoever did not own the bus last.
                    if (last_owner_q) begin
                        state_d      = OWN0;
                        last_owner_d = 1'b0;
                    end else begin
                        state_d      = OWN1;
                        last_owner_d = 1'b1;
                    end
                end else if (req0) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                end else if (req1) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                end
            end

            OWN0: begin
                if (req0) begin
                    spi_select_d     = sel0_n;
                    spi_mosi_d       = mosi0;
                    spi_clk_enable_d = clk_en0;
                end else begin
                    state_d     = GUARD;
                    guard_cnt_d = GUARD_LOAD;
                end
            end

            OWN1: begin
                if (req1) begin
                    spi_select_d     = sel1_n;
                    spi_mosi_d       = mosi1;
                    spi_clk_enable_d = clk_en1;
                end else begin
                    state_d     = GUARD;
                    guard_cnt_d = GUARD_LOAD;
                end
            end

            GUARD: begin
                // Requests are deliberately ignored here. A pending request
                // is picked up once the FSM is back in IDLE.
                if (guard_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and the registered bus outputs live in one block. Reset is
    // asynchronous, so an in-flight transaction is cut off (select high)
    // without waiting for a clock edge. last_owner resets to 1 so that the
    // first contested grant goes to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            last_owner_q     <= 1'b1;
            guard_cnt_q      <= 4'd0;
            spi_select_q     <= 1'b1;
            spi_mosi_q       <= 1'b0;
            spi_clk_enable_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_owner_q     <= last_owner_d;
            guard_cnt_q      <= guard_cnt_d;
            spi_select_q     <= spi_select_d;
            spi_mosi_q       <= spi_mosi_d;
            spi_clk_enable_q <= spi_clk_enable_d;
        end
    end

    // Grants and busy are pure decodes of the state register. They are
    // therefore glitch-free, mutually exclusive and cleared at once by reset.
    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign busy = (state_q != IDLE);

    // Return data goes only to the current owner.
    assign miso0 = gnt0 & spi_miso;
    assign miso1 = gnt1 & spi_miso;

    assign spi_select     = spi_select_q;
    assign spi_mosi       = spi_mosi_q;
    assign spi_clk_enable = spi_clk_enable_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter. The outputs are packed into one
// vector: {gnt0, gnt1, busy, spi_select, spi_mosi, spi_clk_enable, miso0, miso1}.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point.

module tb_spi_bus_arbiter;

    localparam int GUARD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, sel0_n = 1'b1, mosi0 = 1'b0, clk_en0 = 1'b0;
    logic req1 = 1'b0, sel1_n = 1'b1, mosi1 = 1'b0, clk_en1 = 1'b0;
    logic spi_miso = 1'b0;
    logic gnt0, gnt1, miso0, miso1, spi_select, spi_mosi, spi_clk_enable, busy;
    logic [7:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    spi_bus_arbiter #(.GUARD_CYCLES(GUARD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .sel0_n(sel0_n), .mosi0(mosi0), .clk_en0(clk_en0), .gnt0(gnt0),
        .req1(req1), .sel1_n(sel1_n), .mosi1(mosi1), .clk_en1(clk_en1), .gnt1(gnt1),
        .spi_miso(spi_miso), .miso0(miso0), .miso1(miso1),
        .spi_select(spi_select), .spi_mosi(spi_mosi),
        .spi_clk_enable(spi_clk_enable), .busy(busy)
    );

    assign obs = {gnt0, gnt1, busy, spi_select, spi_mosi, spi_clk_enable, miso0, miso1};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop both requests and wait (bounded) for the arbiter to return to IDLE.
    task automatic drain(input string tag);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 12 && busy; i++) step();
        n_tests++;
        if (obs !== {6'b000100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_%s: obs=%b exp=%b", tag, obs, 8'b0001_0000);
        end
        sel0_n = 1'b1; mosi0 = 1'b0; clk_en0 = 1'b0;
        sel1_n = 1'b1; mosi1 = 1'b0; clk_en1 = 1'b0;
    endtask

    task automatic test_reset();
        spi_miso = 1'b1;
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if (obs !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL reset_state: obs=%b exp=%b", obs, 8'b0001_0000);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (obs !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL reset_release_idle: obs=%b exp=%b", obs, 8'b0001_0000);
        end
    endtask

    // Contested request after reset goes to requester 0. After it releases,
    // select stays high GUARD+1 cycles and then requester 1 is granted.
    task automatic test_rr_guard();
        logic [7:0] exp;
        spi_miso = 1'b1;
        req0 = 1'b1; req1 = 1'b1; sel0_n = 1'b0;
        step();
        n_tests++;
        if (obs !== 8'b1011_0010) begin
            n_fail++;
            $display("FAIL rr_first_grant: obs=%b exp=%b", obs, 8'b1011_0010);
        end
        step();
        n_tests++;
        if (obs !== 8'b1010_0010) begin
            n_fail++;
            $display("FAIL rr_own0_select: obs=%b exp=%b", obs, 8'b1010_0010);
        end
        req0 = 1'b0;
        for (int i = 0; i <= GUARD; i++) begin
            step();
            exp = (i < GUARD) ? 8'b0011_0000 : 8'b0001_0000;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rr_gap%0d: obs=%b exp=%b", i, obs, exp);
            end
        end
        step();
        n_tests++;
        if (obs !== 8'b0111_0001) begin
            n_fail++;
            $display("FAIL rr_grant1_after_guard: obs=%b exp=%b", obs, 8'b0111_0001);
        end
        drain("rr");
    endtask

    // Both requesters keep asking. Each owner releases for one edge and then
    // re-requests. Grants must alternate, with GUARD+1 cycles between them.
    task automatic test_back_to_back();
        logic exp_owner;
        int   cnt;
        int   exp_cnt;
        exp_owner = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cnt = 0;
            while (!(gnt0 || gnt1) && cnt < 20) begin
                step();
                cnt++;
            end
            n_tests++;
            if ({gnt0, gnt1} !== (exp_owner ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL b2b_owner_r%0d: gnt=%b%b exp_owner=%0d", r, gnt0, gnt1, exp_owner);
            end
            exp_cnt = (r == 0) ? 1 : GUARD + 1;
            n_tests++;
            if (cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL b2b_wait_r%0d: cycles=%0d exp=%0d", r, cnt, exp_cnt);
            end
            step();
            if (exp_owner) req1 = 1'b0; else req0 = 1'b0;
            step();
            n_tests++;
            if ({gnt0, gnt1, busy, spi_select} !== 4'b0011) begin
                n_fail++;
                $display("FAIL b2b_release_r%0d: gnt=%b%b busy=%b sel=%b exp 0011", r, gnt0, gnt1, busy, spi_select);
            end
            req0 = 1'b1; req1 = 1'b1;
            exp_owner = ~exp_owner;
        end
        drain("b2b");
    endtask

    // Owner's select/mosi/clk_en reach the bus one cycle later, and are
    // forced inactive on release even though sel0_n is still low.
    task automatic test_passthrough();
        logic [2:0] mv;
        logic [2:0] cv;
        logic [7:0] exp;
        mv = 3'b101;
        cv = 3'b011;
        spi_miso = 1'b1;
        req0 = 1'b1; sel0_n = 1'b0; mosi0 = 1'b1; clk_en0 = 1'b1;
        step();
        n_tests++;
        if (obs !== 8'b1011_0010) begin
            n_fail++;
            $display("FAIL pt_entry: obs=%b exp=%b", obs, 8'b1011_0010);
        end
        for (int i = 2; i >= 0; i--) begin
            mosi0 = mv[i];
            clk_en0 = cv[i];
            step();
            exp = {3'b101, 1'b0, mv[i], cv[i], 2'b10};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pt_bit%0d: obs=%b exp=%b", i, obs, exp);
            end
        end
        mosi0 = 1'b1; clk_en0 = 1'b1;
        req0 = 1'b0;
        step();
        n_tests++;
        if (obs !== 8'b0011_0000) begin
            n_fail++;
            $display("FAIL pt_release_forced: obs=%b exp=%b", obs, 8'b0011_0000);
        end
        drain("pt");
    endtask

    // While requester 0 owns the bus, requester 1's signals must not leak
    // through, and requester 1 dropping its pending request changes nothing.
    task automatic test_isolation();
        spi_miso = 1'b1;
        req0 = 1'b1; sel0_n = 1'b1; mosi0 = 1'b0; clk_en0 = 1'b0;
        step();
        req1 = 1'b1; sel1_n = 1'b0; clk_en1 = 1'b1; mosi1 = 1'b1;
        step();
        n_tests++;
        if (obs !== 8'b1011_0010) begin
            n_fail++;
            $display("FAIL iso_own0: obs=%b exp=%b", obs, 8'b1011_0010);
        end
        step();
        n_tests++;
        if (obs !== 8'b1011_0010) begin
            n_fail++;
            $display("FAIL iso_no_preempt: obs=%b exp=%b", obs, 8'b1011_0010);
        end
        req1 = 1'b0;
        step();
        n_tests++;
        if (obs !== 8'b1011_0010) begin
            n_fail++;
            $display("FAIL iso_nonowner_drop: obs=%b exp=%b", obs, 8'b1011_0010);
        end
        spi_miso = 1'b0;
        #1;
        n_tests++;
        if (obs !== 8'b1011_0000) begin
            n_fail++;
            $display("FAIL iso_miso_follow: obs=%b exp=%b", obs, 8'b1011_0000);
        end
        drain("iso");
    endtask

    // Reset in the middle of OWN1 clears everything before the next edge.
    // After requester 0 has owned the bus, a reset must still make
    // requester 0 win the first contested request.
    task automatic test_reset_abort();
        spi_miso = 1'b1;
        req1 = 1'b1; sel1_n = 1'b0; mosi1 = 1'b1; clk_en1 = 1'b1;
        step();
        step();
        n_tests++;
        if (obs !== 8'b0110_1101) begin
            n_fail++;
            $display("FAIL abort_own1: obs=%b exp=%b", obs, 8'b0110_1101);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL abort_async: obs=%b exp=%b", obs, 8'b0001_0000);
        end
        req1 = 1'b0; sel1_n = 1'b1; mosi1 = 1'b0; clk_en1 = 1'b0;
        step();
        rst = 1'b0;
        req0 = 1'b1;
        step();
        step();
        drain("abort_own0");
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        step();
        n_tests++;
        if (obs !== 8'b1011_0010) begin
            n_fail++;
            $display("FAIL first_after_reset: obs=%b exp=%b", obs, 8'b1011_0010);
        end
        drain("final");
    endtask

    initial begin
        test_reset();
        test_rr_guard();
        test_back_to_back();
        test_passthrough();
        test_isolation();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
